// File: rtl/inst_fetch_unit_if.sv
// rtl/inst_fetch_unit_if.sv - fetch-unit bus bundle: decoder control, ROM port and IF/ID register
//
// Purpose: groups every non-clock signal of inst_fetch_unit so the fetch unit and
// its environment connect through one port.
// Signals:
//   stall          decode busy, hold PC and IF/ID
//   branch_taken   taken beq resolved for the instruction in IF/ID
//   branch_offset  signed 16-bit word offset of the beq
//   jump           j resolved for the instruction in IF/ID
//   jump_index     26-bit instr_index of the j
//   inst_in        ROM word for pc_out, same cycle
//   pc_out         current fetch address (ROM address)
//   if_id_inst     latched instruction
//   if_id_pc4      latched fetch address + 4
//   if_id_valid    IF/ID holds a real instruction (0 = bubble)
//   fetch_cnt, bubble_cnt  performance counters, present only with IFETCH_PERF_CNT_EN
// Modports: master = decoder/ROM side, slave = fetch unit.
interface inst_fetch_unit_if;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] inst_in;
  logic [31:0] pc_out;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;

  modport master (
    output stall, branch_taken, branch_offset, jump, jump_index, inst_in,
    input  pc_out, if_id_inst, if_id_pc4, if_id_valid, fetch_cnt, bubble_cnt
  );
  modport slave (
    input  stall, branch_taken, branch_offset, jump, jump_index, inst_in,
    output pc_out, if_id_inst, if_id_pc4, if_id_valid, fetch_cnt, bubble_cnt
  );
`else
  modport master (
    output stall, branch_taken, branch_offset, jump, jump_index, inst_in,
    input  pc_out, if_id_inst, if_id_pc4, if_id_valid
  );
  modport slave (
    input  stall, branch_taken, branch_offset, jump, jump_index, inst_in,
    output pc_out, if_id_inst, if_id_pc4, if_id_valid
  );
`endif
endinterface

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - MIPS fetch stage: PC, next-PC selection and IF/ID register
//
// Purpose: holds the PC that addresses the combinational instruction ROM and
// latches the returned word, PC+4 and a valid flag into IF/ID. A taken branch or
// jump from decode redirects the PC and replaces the wrong-path fetch by a bubble;
// stall holds both PC and IF/ID.
// Parameters: RESET_PC (word aligned reset PC), NOP_INST (bubble instruction word).
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    inst_fetch_unit_if.slave (see interface file for the signal list)
// Optional feature: define IFETCH_PERF_CNT_EN to add fetch_cnt/bubble_cnt counters.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  inst_fetch_unit_if.slave  bus
);

  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] pc4_q;
  logic        valid_q;

  logic        take_jump;
  logic        take_branch;
  logic        take_fetch;
  logic        flush;
  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic [31:0] flush_target;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  // Next state: BOOT lasts exactly one cycle, RUN is permanent until reset
  always_comb begin
    state_next = state;
    case (state)
      BOOT:    state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  // Outputs of the FSM: which action this edge performs.
  // Only a real instruction in IF/ID may redirect, and never during BOOT.
  always_comb begin
    take_jump   = 1'b0;
    take_branch = 1'b0;
    take_fetch  = 1'b0;
    if (state == RUN) begin
      take_jump   = valid_q && bus.jump;
      take_branch = valid_q && bus.branch_taken && !bus.jump;
      take_fetch  = !take_jump && !take_branch && !bus.stall;
    end
  end

  assign flush         = take_jump || take_branch;
  assign pc_plus4      = pc_q + 32'd4;
  assign jump_target   = {pc4_q[31:28], bus.jump_index, 2'b00};
  assign branch_target = pc4_q + {{14{bus.branch_offset[15]}}, bus.branch_offset, 2'b00};
  assign flush_target  = take_jump ? jump_target : branch_target;

  // PC and IF/ID register; a bubble uses the same values as reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else if (flush) begin
      pc_q    <= flush_target;
      inst_q  <= NOP_INST;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else if (take_fetch) begin
      pc_q    <= pc_plus4;
      inst_q  <= bus.inst_in;
      pc4_q   <= pc_plus4;
      valid_q <= 1'b1;
    end
  end

  assign bus.pc_out      = pc_q;
  assign bus.if_id_inst  = inst_q;
  assign bus.if_id_pc4   = pc4_q;
  assign bus.if_id_valid = valid_q;

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] bubble_cnt_q;

  // Every RUN edge that does not fetch is either a stall or a flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q  <= 32'h0;
      bubble_cnt_q <= 32'h0;
    end else begin
      if (take_fetch) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if ((state == RUN) && !take_fetch) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
    end
  end

  assign bus.fetch_cnt  = fetch_cnt_q;
  assign bus.bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - self-checking bench for inst_fetch_unit
module tb_inst_fetch_unit;

  logic clk;
  logic rst_n;

  inst_fetch_unit_if m_if ();
  inst_fetch_unit_if w_if ();

  inst_fetch_unit u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m_if)
  );

  inst_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (w_if)
  );

  logic [31:0] rom [64];

  assign m_if.inst_in = rom[m_if.pc_out[7:2]];
  assign w_if.inst_in = rom[w_if.pc_out[7:2]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        stall;
    logic        br;
    logic [15:0] off;
    logic        jmp;
    logic [25:0] idx;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        valid;
  } vec_t;

  vec_t tbl [40];
  int   n_vec;
  int   checks;
  int   failures;

  logic [31:0] wrap_exp [3];

  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    return rom[addr[7:2]];
  endfunction

  task automatic add(input logic s, input logic b, input logic [15:0] o, input logic j,
                     input logic [25:0] x, input logic [31:0] pc, input logic [31:0] inst,
                     input logic [31:0] pc4, input logic v);
    tbl[n_vec] = '{s, b, o, j, x, pc, inst, pc4, v};
    n_vec++;
  endtask

  // Straight-line fetches: pc_out advances, IF/ID holds the word fetched at pc-4
  task automatic add_run(input logic [31:0] start_pc, input int count);
    logic [31:0] p;
    for (int k = 0; k < count; k++) begin
      p = start_pc + 32'(4 * k);
      add(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, p, rom_word(p - 32'd4), p, 1'b1);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                             input logic [31:0] pc4, input logic v);
    chk({tag, ".pc_out"}, m_if.pc_out, pc);
    chk({tag, ".if_id_inst"}, m_if.if_id_inst, inst);
    chk({tag, ".if_id_pc4"}, m_if.if_id_pc4, pc4);
    chk({tag, ".if_id_valid"}, {31'h0, m_if.if_id_valid}, {31'h0, v});
  endtask

  task automatic drive_idle();
    m_if.stall = 1'b0; m_if.branch_taken = 1'b0; m_if.branch_offset = 16'h0;
    m_if.jump = 1'b0; m_if.jump_index = 26'h0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    n_vec = 0;
    rst_n = 1'b0;
    drive_idle();
    w_if.stall = 1'b0; w_if.branch_taken = 1'b0; w_if.branch_offset = 16'h0;
    w_if.jump = 1'b0; w_if.jump_index = 26'h0;

    for (int i = 0; i < 64; i++) rom[i] = 32'h2400_0000 + 32'(i);
    rom[0] = 32'h0000_0000;
    rom[1] = 32'h3c01_1234;
    rom[2] = 32'h3c02_5678;
    rom[3] = 32'h0022_1820;
    rom[8] = 32'h0063_1826;

    wrap_exp[0] = 32'hFFFF_FFF8;
    wrap_exp[1] = 32'hFFFF_FFFC;
    wrap_exp[2] = 32'h0000_0000;

    // Edge 1: BOOT, PC held at reset value, IF/ID still a bubble
    add(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    // Edges 2..5: 4, 8, 12, 0x10
    add_run(32'h4, 4);
    // Three stalled edges at pc 0x10
    for (int k = 0; k < 3; k++)
      add(1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 32'h10, 32'h0022_1820, 32'h10, 1'b1);
    // Resume at 0x14 up to pc 0x34
    add_run(32'h14, 9);
    // beq off=-5 from pc4 0x34 -> 0x20, bubble
    add(1'b0, 1'b1, 16'hFFFB, 1'b0, 26'h0, 32'h20, 32'h0, 32'h0, 1'b0);
    // Target word arrives: ram[8]
    add_run(32'h24, 8);
    // jump and branch together: jump wins, target 0x40
    add(1'b0, 1'b1, 16'h0004, 1'b1, 26'h10, 32'h40, 32'h0, 32'h0, 1'b0);
    // Jump during the bubble is ignored
    add(1'b0, 1'b0, 16'h0, 1'b1, 26'h100, 32'h44, rom_word(32'h40), 32'h44, 1'b1);
    // Branch beats stall; target 0x44 - 0x80 wraps below zero
    add(1'b1, 1'b1, 16'hFFE0, 1'b0, 26'h0, 32'hFFFF_FFC4, 32'h0, 32'h0, 1'b0);
    // Stall while holding a bubble: nothing moves
    add(1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 32'hFFFF_FFC4, 32'h0, 32'h0, 1'b0);
    add(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 32'hFFFF_FFC8, rom_word(32'hFFFF_FFC4), 32'hFFFF_FFC8, 1'b1);
    // Jump keeps pc4[31:28]=0xF
    add(1'b0, 1'b0, 16'h0, 1'b1, 26'h20, 32'hF000_0080, 32'h0, 32'h0, 1'b0);
    add(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 32'hF000_0084, rom_word(32'hF000_0080), 32'hF000_0084, 1'b1);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_outputs("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    chk("reset.wrap_pc", w_if.pc_out, 32'hFFFF_FFF8);

    for (int i = 0; i < n_vec; i++) begin
      @(negedge clk);
      if (i == 0) rst_n = 1'b1;
      m_if.stall         = tbl[i].stall;
      m_if.branch_taken  = tbl[i].br;
      m_if.branch_offset = tbl[i].off;
      m_if.jump          = tbl[i].jmp;
      m_if.jump_index    = tbl[i].idx;
      @(posedge clk);
      #1;
      chk_outputs($sformatf("vec%0d", i), tbl[i].pc, tbl[i].inst, tbl[i].pc4, tbl[i].valid);
      if (i < 3) chk($sformatf("wrap%0d.pc_out", i), w_if.pc_out, wrap_exp[i]);
    end

    // Asynchronous reset between edges takes effect before the next edge
    @(negedge clk);
    drive_idle();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_outputs("async_rst", 32'h0, 32'h0, 32'h0, 1'b0);
    chk("async_rst.wrap_pc", w_if.pc_out, 32'hFFFF_FFF8);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_outputs("reboot", 32'h0, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    chk_outputs("refetch", 32'h4, 32'h0, 32'h4, 1'b1);

`ifdef IFETCH_PERF_CNT_EN
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("cnt_rst.fetch_cnt", m_if.fetch_cnt, 32'h0);
    chk("cnt_rst.bubble_cnt", m_if.bubble_cnt, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    m_if.stall = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("cnt.fetch_cnt", m_if.fetch_cnt, 32'd10);
    chk("cnt.bubble_cnt", m_if.bubble_cnt, 32'd2);
    m_if.stall = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
